scm_stat_mc: RTL and testbench
==============================

// Module: scm_stat_mc
// PURPOSE
// Multi-channel statistics collector in the MD/PHV pipeline, placed after gme and before the next pipeline stage.
// - Buffers MD and PHV in paired FIFOs and forwards them in lockstep.
// - While a measurement window is open, accumulates per-channel packet/byte counts for packets tagged with LMID.
// - Exposes counters on the localbus; configure packets pass straight through.
// PARAMETERS
// MD_W      256   metadata width
// PHV_W     1024  PHV width
// FIFO_AW   8     FIFO address width (depth 2**FIFO_AW)
// ALF_TH    250   FIFO usedw above which upstream almost-full asserts
// NCH       4     statistic channels (power of 2, 1..16)
// LMID      8'd7  module ID selecting counted packets
// TIMEOUT   32'd1000000  idle cycles before window auto-closes (0 = disabled)
// PORTS
// clk            in   1      clock
// rst_n          in   1      asynchronous reset, active-low
// in_md/_wr      in   MD_W/1 MD from gme, write strobe
// out_md_alf     out  1      in_md_alf | md_usedw>ALF_TH
// in_phv/_wr     in   PHV_W/1 PHV from gme, write strobe
// out_phv_alf    out  1      in_phv_alf | phv_usedw>ALF_TH
// out_md/_wr     out  MD_W/1 MD to next stage
// in_md_alf      in   1      downstream MD almost-full
// out_phv/_wr    out  PHV_W/1 PHV to next stage
// in_phv_alf     in   1      downstream PHV almost-full
// stat_start     in   1      pulse: open window, clear counters
// stat_end       in   1      pulse: close window
// cfg_cs_n       in   1      localbus select, active-low
// cfg_ack_n      out  1      localbus ack, active-low
// cfg_rw         in   1      0 write, 1 read
// cfg_addr       in   32     byte address
// cfg_wdata      in   32     write data
// cfg_rdata      out  32     read data
// cin_data/_wr   in   134/1  config pkt in; cout_ready = cin_ready
// cout_data/_wr  out  134/1  config pkt out, combinational copy of cin
// cin_ready      in   1      downstream config ready
// BEHAVIOUR
// - Reset: all outputs 0 except cfg_ack_n=1; FIFOs empty; window closed; counters 0; FSM IDLE.
// - Forwarding: pop both FIFOs (show-ahead) when both non-empty & !in_md_alf & !in_phv_alf; out_*_wr=1 next cycle with popped data, else 0 and data 0.
//   Latency 1 clk from pop; 1 pkt/clk max. One FIFO non-empty alone -> wait, never pop singly.
// - FSM (window): IDLE -start-> COUNT; COUNT -end-> IDLE; COUNT -idle_cnt==TIMEOUT-> IDLE with status.timeout=1.
//   start & end same cycle: end wins. start in COUNT: restart (counters cleared).
// - Counting in COUNT on each pop with MD[87:80]==LMID: ch=MD[71:64] mod NCH; pkt[ch]+=1; byte[ch]+=MD[111:96].
//   Both counters 64-bit, wrap. time_cnt increments every COUNT cycle. idle_cnt resets on each counted pop.
// - Ctrl write bit0=1 clears all counters; clear beats same-cycle increment.
// - Localbus: cs_n sampled low -> access at next edge, ack_n=0 one clk later, held until cs_n=1; one access per cs_n assertion.
//   Unmapped read returns 0; unmapped write ignored.
//   Map: 0x00 status {30'b0,timeout,window} RO; 0x04 ctrl WO; 0x08/0x0C time lo/hi;
//   0x10+ch*0x10: +0 pkt lo, +4 pkt hi, +8 byte lo, +C byte hi.
// - Async reset mid-packet discards FIFO contents and clears counters.
// STRUCTURE
// - Package scm_pkg: address map constants, MID/CH/LEN bit ranges, FSM state enum.
// - Sub-module scm_sfifo (show-ahead sync FIFO, params W/AW, usedw out), instantiated twice.
// TESTING
// - 3 MD+PHV pairs, no alf -> 3 out pulses, data in order, 1 clk after pop.
// - in_md_alf=1 during 5 writes -> no output; release -> 5 back-to-back outputs.
// - start; 4 pkts MID=7 ch=2 len=64; end -> pkt[2]=4, byte[2]=256, others 0.
// - Same with MID=5 -> counters 0, packets still forwarded.
// - TIMEOUT=16, start then idle 16 clk -> status=0x2, counting stops.
// - Read 0x30 (ch2 pkt lo) -> ack_n low 2 clk after cs_n, rdata=4; write ctrl=1 -> reads 0.

Source files
------------

// File: rtl/scm_pkg.sv
// scm_pkg: shared definitions for the scm_stat_mc statistics collector.
//   - localbus register map
//   - bit positions of the MID / channel / length fields inside MD
//   - measurement-window FSM states
package scm_pkg;

    // Localbus register map (byte addresses)
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_0000;
    localparam logic [31:0] ADDR_CTRL    = 32'h0000_0004;
    localparam logic [31:0] ADDR_TIME_LO = 32'h0000_0008;
    localparam logic [31:0] ADDR_TIME_HI = 32'h0000_000C;
    // Channel ch occupies 0x10 + ch*0x10 .. +0xC
    localparam logic [31:0] ADDR_CH_BASE = 32'h0000_0010;

    // MD field positions
    localparam int MID_HI = 87;
    localparam int MID_LO = 80;
    localparam int CH_HI  = 71;
    localparam int CH_LO  = 64;
    localparam int LEN_HI = 111;
    localparam int LEN_LO = 96;

    typedef struct packed {
        logic [15:0] len;
        logic [7:0]  mid;
        logic [7:0]  ch;
    } md_tag_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } win_state_e;

endpackage

// File: rtl/scm_sfifo.sv
// scm_sfifo: show-ahead synchronous FIFO.
//   clk, rst_n : clock, async active-low reset (pointers / fill level only)
//   wr, wdata  : push (ignored when full)
//   rd         : pop (ignored when empty); rdata always shows the head entry
//   empty      : no entries
//   usedw      : fill level, AW+1 bits so a full FIFO is representable
module scm_sfifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [AW:0]   usedw
);

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] wp, rp;
    logic          full, do_wr, do_rd;

    assign full  = usedw[AW];
    assign empty = (usedw == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = mem[rp];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            usedw <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/scm_stat_mc.sv
// scm_stat_mc: multi-channel statistics collector between gme and the next stage.
//   in_md/in_phv (+_wr)   : MD/PHV from gme, buffered in paired FIFOs
//   out_md_alf/out_phv_alf: upstream almost-full (downstream alf or FIFO above ALF_TH)
//   out_md/out_phv (+_wr) : lockstep forwarded MD/PHV, 1 clk after the pop
//   in_md_alf/in_phv_alf  : downstream almost-full, stall popping
//   stat_start/stat_end   : open (clearing counters) / close the measurement window
//   cfg_*                 : localbus slave exposing status, ctrl, time and per-channel counters
//   cin_*/cout_*          : config packets, passed straight through combinationally
module scm_stat_mc
    import scm_pkg::*;
#(
    parameter int          MD_W    = 256,
    parameter int          PHV_W   = 1024,
    parameter int          FIFO_AW = 8,
    parameter int          ALF_TH  = 250,
    parameter int          NCH     = 4,
    parameter logic [7:0]  LMID    = 8'd7,
    parameter logic [31:0] TIMEOUT = 32'd1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MD_W-1:0]   in_md,
    input  logic              in_md_wr,
    output logic              out_md_alf,
    input  logic [PHV_W-1:0]  in_phv,
    input  logic              in_phv_wr,
    output logic              out_phv_alf,
    output logic [MD_W-1:0]   out_md,
    output logic              out_md_wr,
    input  logic              in_md_alf,
    output logic [PHV_W-1:0]  out_phv,
    output logic              out_phv_wr,
    input  logic              in_phv_alf,
    input  logic              stat_start,
    input  logic              stat_end,
    input  logic              cfg_cs_n,
    output logic              cfg_ack_n,
    input  logic              cfg_rw,
    input  logic [31:0]       cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    input  logic [133:0]      cin_data,
    input  logic              cin_wr,
    output logic [133:0]      cout_data,
    output logic              cout_wr,
    input  logic              cin_ready,
    output logic              cout_ready
);

    // ---------------- FIFOs and lockstep forwarding ----------------
    logic [MD_W-1:0]  md_q;
    logic [PHV_W-1:0] phv_q;
    logic             md_empty, phv_empty, pop;
    logic [FIFO_AW:0] md_usedw, phv_usedw;

    // Pop only as a pair: a lone MD or PHV waits for its partner.
    assign pop = !md_empty && !phv_empty && !in_md_alf && !in_phv_alf;

    scm_sfifo #(.W(MD_W), .AW(FIFO_AW)) u_md_fifo (
        .clk(clk), .rst_n(rst_n), .wr(in_md_wr), .wdata(in_md),
        .rd(pop), .rdata(md_q), .empty(md_empty), .usedw(md_usedw)
    );

    scm_sfifo #(.W(PHV_W), .AW(FIFO_AW)) u_phv_fifo (
        .clk(clk), .rst_n(rst_n), .wr(in_phv_wr), .wdata(in_phv),
        .rd(pop), .rdata(phv_q), .empty(phv_empty), .usedw(phv_usedw)
    );

    assign out_md_alf  = in_md_alf  | (int'(md_usedw)  > ALF_TH);
    assign out_phv_alf = in_phv_alf | (int'(phv_usedw) > ALF_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_md_wr  <= 1'b0;
            out_phv_wr <= 1'b0;
            out_md     <= '0;
            out_phv    <= '0;
        end else begin
            out_md_wr  <= pop;
            out_phv_wr <= pop;
            out_md     <= pop ? md_q  : '0;
            out_phv    <= pop ? phv_q : '0;
        end
    end

    // ---------------- Measurement window ----------------
    win_state_e  state, state_nxt;
    md_tag_t     tag;
    logic [7:0]  ch_sel;
    logic [31:0] idle_cnt;
    logic [63:0] time_cnt;
    logic [NCH-1:0][63:0] pkt_cnt, byte_cnt;
    logic        timeout_flag, to_hit, start_clr, ctrl_clr, counting;

    assign tag.len  = md_q[LEN_HI:LEN_LO];
    assign tag.mid  = md_q[MID_HI:MID_LO];
    assign tag.ch   = md_q[CH_HI:CH_LO];
    assign ch_sel   = tag.ch & 8'(NCH - 1);   // NCH is a power of 2
    assign counting = (state == ST_COUNT) && pop && (tag.mid == LMID);
    assign to_hit   = (TIMEOUT != 32'd0) && (idle_cnt == TIMEOUT);
    // stat_end beats a same-cycle stat_start, so that start neither opens nor clears.
    assign start_clr = stat_start && !stat_end;

    always_comb begin
        state_nxt = state;
        if (stat_end)                        state_nxt = ST_IDLE;
        else if (stat_start)                 state_nxt = ST_COUNT;
        else if (state == ST_COUNT && to_hit) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            timeout_flag <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (start_clr)
                timeout_flag <= 1'b0;
            else if (state == ST_COUNT && !stat_end && to_hit)
                timeout_flag <= 1'b1;
            if (start_clr)
                idle_cnt <= '0;
            else if (state == ST_COUNT)
                idle_cnt <= counting ? 32'd0 : idle_cnt + 32'd1;
        end
    end

    // Clears (start or ctrl write) take priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_cnt <= '0;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
        end else if (start_clr || ctrl_clr) begin
            time_cnt <= '0;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            if (state == ST_COUNT) time_cnt <= time_cnt + 64'd1;
            for (int c = 0; c < NCH; c++) begin
                if (counting && ch_sel == 8'(c)) begin
                    pkt_cnt[c]  <= pkt_cnt[c] + 64'd1;
                    byte_cnt[c] <= byte_cnt[c] + {48'd0, tag.len};
                end
            end
        end
    end

    // ---------------- Localbus ----------------
    // cs_n is registered first; the access happens on the following edge and
    // ack_n drops together with it. acc_done limits each cs_n assertion to one access.
    logic        cs_q, acc_done, access;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign access       = cs_q && !cfg_cs_n && !acc_done;
    assign ctrl_clr     = access && !cfg_rw && (cfg_addr == ADDR_CTRL) && cfg_wdata[0];
    assign unused_wdata = ^cfg_wdata[31:1];

    always_comb begin
        rd_mux = '0;
        if (cfg_addr == ADDR_STATUS)       rd_mux = {30'd0, timeout_flag, state == ST_COUNT};
        else if (cfg_addr == ADDR_TIME_LO) rd_mux = time_cnt[31:0];
        else if (cfg_addr == ADDR_TIME_HI) rd_mux = time_cnt[63:32];
        else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_addr[31:4] == 28'(c + 1) && cfg_addr[1:0] == 2'b00) begin
                    case (cfg_addr[3:2])
                        2'd0:    rd_mux = pkt_cnt[c][31:0];
                        2'd1:    rd_mux = pkt_cnt[c][63:32];
                        2'd2:    rd_mux = byte_cnt[c][31:0];
                        default: rd_mux = byte_cnt[c][63:32];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q      <= 1'b0;
            acc_done  <= 1'b0;
            cfg_ack_n <= 1'b1;
            cfg_rdata <= '0;
        end else begin
            cs_q <= !cfg_cs_n;
            if (cfg_cs_n) begin
                acc_done  <= 1'b0;
                cfg_ack_n <= 1'b1;
            end else if (access) begin
                acc_done  <= 1'b1;
                cfg_ack_n <= 1'b0;
                if (cfg_rw) cfg_rdata <= rd_mux;
            end
        end
    end

    // ---------------- Config packet passthrough ----------------
    assign cout_data  = cin_data;
    assign cout_wr    = cin_wr;
    assign cout_ready = cin_ready;

endmodule

// File: tb/tb_scm_stat_mc.sv
// tb_scm_stat_mc: self-checking bench for scm_stat_mc (queue-based reference model,
// table of localbus reads, directed corner sequences, randomized traffic).
module tb_scm_stat_mc;

    localparam int          MD_W   = 256;
    localparam int          PHV_W  = 128;
    localparam int          ALF_TH = 4;
    localparam int          NCH    = 4;
    localparam logic [7:0]  LMID   = 8'd7;
    localparam logic [31:0] TOUT   = 32'd16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [MD_W-1:0]  in_md = '0, out_md;
    logic [PHV_W-1:0] in_phv = '0, out_phv;
    logic in_md_wr = 0, in_phv_wr = 0, in_md_alf = 0, in_phv_alf = 0;
    logic out_md_alf, out_phv_alf, out_md_wr, out_phv_wr;
    logic stat_start = 0, stat_end = 0;
    logic cfg_cs_n = 1, cfg_rw = 0, cfg_ack_n;
    logic [31:0] cfg_addr = '0, cfg_wdata = '0, cfg_rdata;
    logic [133:0] cin_data = '0, cout_data;
    logic cin_wr = 0, cout_wr, cin_ready = 0, cout_ready;

    always #5 clk = ~clk;

    scm_stat_mc #(.MD_W(MD_W), .PHV_W(PHV_W), .FIFO_AW(8), .ALF_TH(ALF_TH),
                  .NCH(NCH), .LMID(LMID), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_md(in_md), .in_md_wr(in_md_wr), .out_md_alf(out_md_alf),
        .in_phv(in_phv), .in_phv_wr(in_phv_wr), .out_phv_alf(out_phv_alf),
        .out_md(out_md), .out_md_wr(out_md_wr), .in_md_alf(in_md_alf),
        .out_phv(out_phv), .out_phv_wr(out_phv_wr), .in_phv_alf(in_phv_alf),
        .stat_start(stat_start), .stat_end(stat_end),
        .cfg_cs_n(cfg_cs_n), .cfg_ack_n(cfg_ack_n), .cfg_rw(cfg_rw),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .cin_data(cin_data), .cin_wr(cin_wr), .cout_data(cout_data),
        .cout_wr(cout_wr), .cin_ready(cin_ready), .cout_ready(cout_ready)
    );

    int n_chk = 0, n_fail = 0, n_out = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [MD_W-1:0]  mq[$];
    logic [PHV_W-1:0] pq[$];
    logic [MD_W-1:0]  e_md;
    logic [PHV_W-1:0] e_phv;
    logic             e_wr;
    bit               m_win, m_to, m_clr;
    logic [31:0]      m_idle;
    logic [63:0]      m_time;
    logic [63:0]      m_pkt[NCH], m_byte[NCH];

    task automatic m_reset();
        mq.delete(); pq.delete();
        e_md = '0; e_phv = '0; e_wr = 0;
        m_win = 0; m_to = 0; m_clr = 0; m_idle = 0; m_time = 0;
        for (int c = 0; c < NCH; c++) begin m_pkt[c] = 0; m_byte[c] = 0; end
    endtask

    // One clock edge of the block's rules, applied to the values sampled at that edge.
    task automatic mdl_edge();
        logic [MD_W-1:0] h;
        bit cnt, fire, old_win, sclr;
        int c;
        cnt = 0; c = 0; h = '0;
        if (mq.size() > 0 && pq.size() > 0 && !in_md_alf && !in_phv_alf) begin
            h = mq.pop_front();
            e_md = h; e_phv = pq.pop_front(); e_wr = 1;
            cnt = m_win && (h[87:80] == LMID);
            c = int'(h[71:64]) % NCH;
        end else begin
            e_md = '0; e_phv = '0; e_wr = 0;
        end
        old_win = m_win;
        fire = old_win && (TOUT != 0) && (m_idle == TOUT);
        sclr = stat_start && !stat_end;
        if (sclr || m_clr) begin
            m_time = 0;
            for (int k = 0; k < NCH; k++) begin m_pkt[k] = 0; m_byte[k] = 0; end
        end else begin
            if (old_win) m_time = m_time + 1;
            if (cnt) begin
                m_pkt[c]  = m_pkt[c] + 1;
                m_byte[c] = m_byte[c] + {48'd0, h[111:96]};
            end
        end
        if (sclr) m_idle = 0;
        else if (old_win) m_idle = cnt ? 0 : m_idle + 1;
        if (stat_end) m_win = 0;
        else if (stat_start) begin m_win = 1; m_to = 0; end
        else if (fire) begin m_win = 0; m_to = 1; end
        if (in_md_wr)  mq.push_back(in_md);
        if (in_phv_wr) pq.push_back(in_phv);
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int c;
        if (a == 32'h0) return {30'd0, m_to, m_win};
        if (a == 32'h8) return m_time[31:0];
        if (a == 32'hC) return m_time[63:32];
        if (a >= 32'h10 && a < 32'h10 + NCH * 16 && a[1:0] == 2'b00) begin
            c = int'((a - 32'h10) / 16);
            case (a[3:2])
                2'd0: return m_pkt[c][31:0];
                2'd1: return m_pkt[c][63:32];
                2'd2: return m_byte[c][31:0];
                default: return m_byte[c][63:32];
            endcase
        end
        return 32'h0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        mdl_edge();
        #1;
        if (out_md_wr) n_out++;
        check("out_wr", {out_md_wr, out_phv_wr}, {e_wr, e_wr});
        check("out_md", out_md, e_md);
        check("out_phv", out_phv, e_phv);
        check("alf", {out_md_alf, out_phv_alf},
              {in_md_alf | (mq.size() > ALF_TH), in_phv_alf | (pq.size() > ALF_TH)});
    endtask

    function automatic logic [MD_W-1:0] make_md(input logic [7:0] mid, input logic [7:0] ch,
                                                input logic [15:0] len);
        logic [MD_W-1:0] m;
        m = '0;
        m[63:0]    = {$urandom, $urandom};
        m[71:64]   = ch;
        m[79:72]   = 8'($urandom);
        m[87:80]   = mid;
        m[95:88]   = 8'($urandom);
        m[111:96]  = len;
        m[175:112] = {$urandom, $urandom};
        return m;
    endfunction

    task automatic idle_in();
        in_md_wr = 0; in_phv_wr = 0; stat_start = 0; stat_end = 0;
    endtask

    task automatic put_pair(input logic [7:0] mid, input logic [7:0] ch, input logic [15:0] len);
        in_md = make_md(mid, ch, len); in_md_wr = 1;
        in_phv = {$urandom, $urandom, $urandom, $urandom}; in_phv_wr = 1;
        cyc();
        idle_in();
    endtask

    task automatic pulse(input bit s, input bit e);
        stat_start = s; stat_end = e;
        cyc();
        idle_in();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] mexp);
        cfg_addr = a; cfg_rw = 1; cfg_cs_n = 0;
        cyc();
        check("ack_n before access", cfg_ack_n, 1'b1);
        mexp = m_read(a);
        cyc();
        check("ack_n at access", cfg_ack_n, 1'b0);
        d = cfg_rdata;
        cyc();
        check("ack_n held", cfg_ack_n, 1'b0);
        cfg_cs_n = 1;
        cyc();
        check("ack_n release", cfg_ack_n, 1'b1);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
        cfg_addr = a; cfg_rw = 0; cfg_wdata = wd; cfg_cs_n = 0;
        cyc();
        m_clr = (a == 32'h4) && wd[0];
        cyc();
        m_clr = 0;
        check("wr ack_n", cfg_ack_n, 1'b0);
        cfg_cs_n = 1;
        cyc();
    endtask

    task automatic rd_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d, me;
        bus_read(a, d, me);
        check(name, d, exp);
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    initial begin
        rd_vec_t tbl[14];
        logic [31:0] d, me;
        int base;

        tbl = '{
            '{"status closed", 32'h00, 32'h0},
            '{"ch2 pkt lo",    32'h30, 32'd4},
            '{"ch2 pkt hi",    32'h34, 32'd0},
            '{"ch2 byte lo",   32'h38, 32'd256},
            '{"ch2 byte hi",   32'h3C, 32'd0},
            '{"ch0 pkt lo",    32'h10, 32'd0},
            '{"ch0 byte lo",   32'h18, 32'd0},
            '{"ch1 pkt lo",    32'h20, 32'd0},
            '{"ch1 byte lo",   32'h28, 32'd0},
            '{"ch3 pkt lo",    32'h40, 32'd0},
            '{"ch3 byte lo",   32'h48, 32'd0},
            '{"unmapped 0x50", 32'h50, 32'd0},
            '{"ctrl is WO",    32'h04, 32'd0},
            '{"misaligned",    32'h32, 32'd0}
        };

        m_reset();
        #12;
        check("rst out_wr", {out_md_wr, out_phv_wr}, 2'b00);
        check("rst out_md", out_md, '0);
        check("rst ack_n", cfg_ack_n, 1'b1);
        check("rst rdata", cfg_rdata, 32'h0);
        check("rst alf", {out_md_alf, out_phv_alf}, 2'b00);
        @(negedge clk);
        rst_n = 1;

        // three pairs straight through
        base = n_out;
        for (int i = 0; i < 3; i++) put_pair(8'd1, 8'(i), 16'd10);
        repeat (3) cyc();
        check("3 pairs out", n_out - base, 3);

        // downstream MD almost-full holds five pairs, then they drain back-to-back
        in_md_alf = 1;
        base = n_out;
        for (int i = 0; i < 5; i++) put_pair(8'd1, 8'd0, 16'd1);
        cyc();
        check("held by md alf", n_out - base, 0);
        in_md_alf = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("back-to-back", out_md_wr, 1'b1);
        end
        cyc();
        check("drained", out_md_wr, 1'b0);

        // out_md_alf threshold: 4 entries is not above ALF_TH, 5 is
        in_phv_alf = 1;
        for (int i = 0; i < 4; i++) put_pair(8'd1, 8'd0, 16'd1);
        check("md alf at 4", out_md_alf, 1'b0);
        put_pair(8'd1, 8'd0, 16'd1);
        check("md alf at 5", out_md_alf, 1'b1);
        in_phv_alf = 0;
        repeat (7) cyc();

        // counted window: 4 x MID=LMID ch=2 len=64
        pulse(1, 0);
        for (int i = 0; i < 4; i++) put_pair(LMID, 8'd2, 16'd64);
        repeat (2) cyc();
        pulse(0, 1);
        cyc();
        foreach (tbl[i]) begin
            bus_read(tbl[i].addr, d, me);
            check(tbl[i].name, d, tbl[i].exp);
        end

        // foreign MID: forwarded, not counted
        pulse(1, 0);
        base = n_out;
        for (int i = 0; i < 4; i++) put_pair(8'd5, 8'd2, 16'd64);
        repeat (2) cyc();
        pulse(0, 1);
        check("mid5 forwarded", n_out - base, 4);
        rd_expect("mid5 pkt", 32'h30, 32'd0);
        rd_expect("mid5 byte", 32'h38, 32'd0);

        // timeout closes the window; later packets are not counted
        pulse(1, 0);
        repeat (20) cyc();
        rd_expect("timeout status", 32'h00, 32'h2);
        put_pair(LMID, 8'd2, 16'd64);
        repeat (2) cyc();
        rd_expect("after timeout pkt", 32'h30, 32'd0);

        // ctrl clear, plus start & end together (end wins)
        pulse(1, 0);
        for (int i = 0; i < 4; i++) put_pair(LMID, 8'd6, 16'd64);   // ch 6 mod 4 = 2
        repeat (2) cyc();
        pulse(1, 1);
        rd_expect("start+end closes", 32'h00, 32'h0);
        rd_expect("ch2 pkt kept", 32'h30, 32'd4);
        bus_write(32'h04, 32'h1);
        rd_expect("ctrl clr pkt", 32'h30, 32'd0);
        rd_expect("ctrl clr byte", 32'h38, 32'd0);

        // clear coinciding with counted pops (model decides what survives)
        pulse(1, 0);
        in_md = make_md(LMID, 8'd1, 16'd3); in_md_wr = 1;
        in_phv = {4{$urandom}}; in_phv_wr = 1;
        bus_write(32'h04, 32'h1);
        idle_in();
        repeat (2) cyc();
        pulse(0, 1);
        bus_read(32'h20, d, me); check("clr vs inc pkt", d, me);
        bus_read(32'h28, d, me); check("clr vs inc byte", d, me);
        bus_read(32'h08, d, me); check("clr vs inc time", d, me);

        // asynchronous reset with packets queued and the window open
        pulse(1, 0);
        in_md_alf = 1;
        for (int i = 0; i < 3; i++) put_pair(LMID, 8'd0, 16'd9);
        rst_n = 0;
        #2;
        m_reset();
        check("async rst out_wr", out_md_wr, 1'b0);
        check("async rst phv alf", out_phv_alf, 1'b0);
        check("async rst rdata", cfg_rdata, 32'h0);
        in_md_alf = 0;
        @(negedge clk);
        rst_n = 1;
        base = n_out;
        repeat (3) cyc();
        check("fifo flushed", n_out - base, 0);
        rd_expect("status after rst", 32'h00, 32'h0);
        rd_expect("ch0 after rst", 32'h10, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_md_wr = ($urandom_range(0, 9) < 5) && (mq.size() < 200);
            if (in_md_wr)
                in_md = make_md(($urandom_range(0, 1) == 1) ? LMID : 8'($urandom),
                                8'($urandom), 16'($urandom));
            in_phv_wr = ($urandom_range(0, 9) < 5) && (pq.size() < 200);
            in_phv = {$urandom, $urandom, $urandom, $urandom};
            in_md_alf  = ($urandom_range(0, 9) == 0);
            in_phv_alf = ($urandom_range(0, 9) == 0);
            stat_start = ($urandom_range(0, 49) == 0);
            stat_end   = ($urandom_range(0, 69) == 0);
            if ($urandom_range(0, 29) == 0) begin
                int idx;
                idx = $urandom_range(0, 3 + NCH * 4);
                idle_in();
                if (idx == 1) bus_write(32'h4, 32'h1);
                else begin
                    bus_read(idx < 4 ? 32'(idx * 4) : 32'h10 + 32'((idx - 4) * 4), d, me);
                    check("rand read", d, me);
                end
            end else begin
                cyc();
            end
        end
        idle_in(); in_md_alf = 0; in_phv_alf = 0;
        pulse(0, 1);
        repeat (4) cyc();
        for (int a = 0; a < 16 + NCH * 16; a += 4) begin
            bus_read(32'(a), d, me);
            check("final read", d, me);
        end

        // config passthrough
        for (int i = 0; i < 4; i++) begin
            cin_data = {6'($urandom), {4{$urandom}}};
            cin_wr = 1'($urandom); cin_ready = 1'($urandom);
            #1;
            check("cfg pkt pass", {cout_data, cout_wr, cout_ready}, {cin_data, cin_wr, cin_ready});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
